perip_flexbus_regfile: RTL and testbench
========================================

// Module: perip_flexbus_regfile
// PURPOSE
// - Parametrised FlexBus slave: N_REGS x 32-bit register file behind a multiplexed address/data FlexBus.
// - Adds programmable wait states, a TA_n acknowledge, byte-lane writes and optional 4-beat bursts.
// - Sits between the MCU FlexBus pins (tristate handled at top level) and the PL peripherals (LED, buzzer, PWM).
// - Each peripheral consumes a slice of REG_Qout.
// PARAMETERS
// - FB_BASE      32'h60000000  base address; only bits [31:28] are compared.
// - N_REGS       5             number of 32-bit registers, 1..64; register k is at FB_BASE + 4*k.
// - WAIT_STATES  1             wait cycles inserted before TA_n for each beat, 0..15.
// PORTS
// - CLK          in   1          bus clock (FB_CLK); all state updates on rising edge.
// - RST          in   1          asynchronous, active-high reset.
// - FB_ALE       in   1          address latch enable; high for one cycle carrying the address on FB_AD_I.
// - FB_CS_n      in   1          chip select, active low.
// - FB_RW        in   1          1 = read, 0 = write.
// - FB_TBST_n    in   1          burst indicator, active low; sampled with ALE.
// - FB_BE_n      in   4          byte enables, active low; bit i gates bits [8i+7:8i].
// - FB_AD_I      in   32         address/data in from the pad.
// - FB_AD_O      out  32         read data to the pad.
// - FB_AD_OE     out  1          pad output enable.
// - FB_TA_n      out  1          transfer acknowledge, active low.
// - REG_Qout     out  32*N_REGS  register contents; register k is at [32k+31:32k].
// - REG_WR_STB   out  N_REGS     one-cycle pulse on the cycle after register k is written.
// BEHAVIOUR
// - Reset values: REG_Qout = 0, REG_WR_STB = 0, FB_AD_O = 0, FB_AD_OE = 0, FB_TA_n = 1, FSM = IDLE.
// - Reset is honoured mid-transaction: the bus is released immediately and no partial write survives.
// - FSM states: IDLE, ADDR, WAIT, ACK.
// - IDLE: on ALE=1 with FB_AD_I[31:28]==FB_BASE[31:28]:
//   - latch word index = FB_AD_I[7:2] and the burst flag = ~FB_TBST_n;
//   - load wait counter = WAIT_STATES; go to ADDR.
// - IDLE: on a base-address mismatch, stay in IDLE and never drive the bus or TA_n.
// - ADDR: when FB_CS_n=0, go to WAIT, or straight to ACK if WAIT_STATES=0.
// - WAIT: decrement the counter each cycle; at 0 go to ACK. Total latency CS_n low -> TA_n low = WAIT_STATES+1 cycles.
// - ACK: FB_TA_n=0 for exactly one cycle.
//   - Write: reg[idx] byte lanes with FB_BE_n[i]=0 take FB_AD_I; REG_WR_STB[idx] pulses on the next cycle.
//   - Read: FB_AD_O already holds reg[idx], registered on entry to WAIT/ACK.
// - Read drive: FB_AD_OE=1 from the first cycle after CS_n low with FB_RW=1 until CS_n returns high or the FSM reaches IDLE.
// - Out-of-range index (idx >= N_REGS) inside the base window:
//   - TA_n is still given, so the bus never hangs;
//   - reads return 32'h0; writes are dropped and no strobe is issued.
// - After ACK, non-burst transactions go to IDLE.
// - FB_CS_n high in any non-IDLE state aborts to IDLE; TA_n stays 1 and no write occurs.
// - ALE=1 while not in IDLE aborts the current transaction and restarts the address phase with the new address, same cycle.
// - Write data and read data reflect the same-cycle register: a read issued one cycle after a write to the same index returns the new value.
// CONFIGURATION
// - FB_BURST_EN defined:
//   - when the burst flag is set, the transaction runs 4 beats; each beat repeats WAIT -> ACK;
//   - idx advances as {idx[5:2], idx[1:0]+1}, i.e. wraps within the aligned 16-byte line;
//   - go to IDLE after the 4th ACK.
// - FB_BURST_EN undefined:
//   - FB_TBST_n is ignored and every transaction is single-beat;
//   - burst logic is absent from the netlist.
// TESTING
// - Reset check: after RST, REG_Qout == 0, FB_TA_n == 1, FB_AD_OE == 0; assert RST mid-WAIT -> bus released the next cycle.
// - Single write: ALE with 0x60000008, CS_n=0, RW=0, BE_n=4'b0000, data 0xDEADBEEF, WAIT_STATES=1
//   -> TA_n low 2 cycles after CS_n; reg2 = 0xDEADBEEF; REG_WR_STB[2] pulses once.
// - Byte-lane write: reg2 = 0xDEADBEEF, write 0x11223344 with BE_n=4'b1010 -> reg2 == 0xDE22BE44.
// - Read: ALE 0x60000008, RW=1 -> FB_AD_OE=1 and FB_AD_O == reg2 on the TA_n cycle.
// - Read out of range: ALE 0x600000FC (N_REGS=5) -> FB_AD_O == 0 and TA_n given.
// - Base mismatch: ALE 0x70000000 -> no TA_n, OE stays 0, registers unchanged.
// - Burst, FB_BURST_EN defined, N_REGS=8: ALE 0x60000018 with TBST_n=0, 4 writes of 1,2,3,4
//   -> reg6=1, reg7=2, reg4=3, reg5=4; 4 TA_n pulses.
// - Burst, FB_BURST_EN undefined: same stimulus -> only reg6 written, single TA_n.
// - Abort: CS_n deasserted during WAIT -> no TA_n, no write, FSM back to IDLE.

Source files
------------

// File: rtl/perip_flexbus_regfile.sv
// FlexBus slave exposing N_REGS x 32-bit registers with wait states, TA_n and byte lanes.
// Define FB_BURST_EN to build in 4-beat wrapping bursts; without it every access is single-beat.
module perip_flexbus_regfile #(
    parameter logic [31:0] FB_BASE     = 32'h6000_0000,
    parameter int          N_REGS      = 5,
    parameter int          WAIT_STATES = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FB_ALE,
    input  logic                  FB_CS_n,
    input  logic                  FB_RW,
    input  logic                  FB_TBST_n,
    input  logic [3:0]            FB_BE_n,
    input  logic [31:0]           FB_AD_I,
    output logic [31:0]           FB_AD_O,
    output logic                  FB_AD_OE,
    output logic                  FB_TA_n,
    output logic [32*N_REGS-1:0]  REG_Qout,
    output logic [N_REGS-1:0]     REG_WR_STB
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_ACK} state_t;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q;
    logic [5:0]        idx_q;
    logic [5:0]        rd_idx_d;
    logic [31:0]       regs_q [N_REGS];
    logic [31:0]       ad_o_q;
    logic [31:0]       rdata_d;
    logic [31:0]       wmask_d;
    logic              oe_q;
    logic              ta_n_q;
    logic [N_REGS-1:0] stb_q;
    logic              base_hit_d;
    logic              in_range_d;
    logic              more_beats_d;
    logic              wr_en_d;
    logic              load_rd_d;

`ifdef FB_BURST_EN
    logic              burst_q;
    logic [1:0]        beat_q;
    logic [5:0]        idx_adv_d;

    // Beats wrap inside the aligned 16-byte line.
    assign idx_adv_d    = {idx_q[5:2], idx_q[1:0] + 2'd1};
    assign more_beats_d = burst_q && (beat_q != 2'd3);
    assign rd_idx_d     = (state_q == S_ACK) ? idx_adv_d : idx_q;
`else
    logic              unused_tbst;

    assign unused_tbst  = FB_TBST_n;
    assign more_beats_d = 1'b0;
    assign rd_idx_d     = idx_q;
`endif

    assign base_hit_d = (FB_AD_I[31:28] == FB_BASE[31:28]);
    assign in_range_d = (int'(idx_q) < N_REGS);
    assign wr_en_d    = (state_q == S_ACK) && !FB_ALE && !FB_CS_n && !FB_RW && in_range_d;
    assign wmask_d    = {{8{~FB_BE_n[3]}}, {8{~FB_BE_n[2]}}, {8{~FB_BE_n[1]}}, {8{~FB_BE_n[0]}}};

    always_comb begin
        rdata_d = 32'h0;
        for (int k = 0; k < N_REGS; k++) begin
            if (rd_idx_d == 6'(k)) begin
                rdata_d = regs_q[k];
            end
        end
    end

    // ALE wins over every state so a new address phase restarts the transaction.
    always_comb begin
        state_d = state_q;
        if (FB_ALE) begin
            state_d = base_hit_d ? S_ADDR : S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_ADDR: begin
                    if (FB_CS_n) state_d = S_IDLE;
                    else         state_d = (WS == 4'd0) ? S_ACK : S_WAIT;
                end
                S_WAIT: begin
                    if (FB_CS_n)             state_d = S_IDLE;
                    else if (cnt_q <= 4'd1)  state_d = S_ACK;
                end
                S_ACK: begin
                    if (FB_CS_n || !more_beats_d) state_d = S_IDLE;
                    else                          state_d = (WS == 4'd0) ? S_ACK : S_WAIT;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Read data is captured whenever a beat begins its wait/ack phase.
    assign load_rd_d = ((state_d == S_WAIT) || (state_d == S_ACK)) && (state_q != S_WAIT);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= 6'd0;
            ad_o_q  <= 32'h0;
            oe_q    <= 1'b0;
            ta_n_q  <= 1'b1;
            stb_q   <= '0;
            for (int k = 0; k < N_REGS; k++) begin
                regs_q[k] <= 32'h0;
            end
`ifdef FB_BURST_EN
            burst_q <= 1'b0;
            beat_q  <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            ta_n_q  <= (state_d != S_ACK);
            oe_q    <= ((state_d == S_WAIT) || (state_d == S_ACK)) && FB_RW && !FB_CS_n;
            stb_q   <= '0;
            if (load_rd_d) begin
                ad_o_q <= rdata_d;
            end
            for (int k = 0; k < N_REGS; k++) begin
                if (wr_en_d && (idx_q == 6'(k))) begin
                    regs_q[k] <= (regs_q[k] & ~wmask_d) | (FB_AD_I & wmask_d);
                    stb_q[k]  <= 1'b1;
                end
            end
            if (FB_ALE) begin
                if (base_hit_d) begin
                    idx_q <= FB_AD_I[7:2];
                    cnt_q <= WS;
`ifdef FB_BURST_EN
                    burst_q <= ~FB_TBST_n;
                    beat_q  <= 2'd0;
`endif
                end
            end else begin
                case (state_q)
                    S_WAIT: cnt_q <= cnt_q - 4'd1;
                    S_ACK: begin
                        if (state_d != S_IDLE) begin
                            cnt_q <= WS;
`ifdef FB_BURST_EN
                            idx_q  <= idx_adv_d;
                            beat_q <= beat_q + 2'd1;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar g = 0; g < N_REGS; g++) begin : g_qout
        assign REG_Qout[32*g +: 32] = regs_q[g];
    end

    assign FB_AD_O    = ad_o_q;
    assign FB_AD_OE   = oe_q;
    assign FB_TA_n    = ta_n_q;
    assign REG_WR_STB = stb_q;

endmodule

// File: tb/tb_perip_flexbus_regfile.sv
// Bench for perip_flexbus_regfile: directed scenarios plus randomized accesses against a
// register-array reference model. Burst expectations follow FB_BURST_EN.
module tb_perip_flexbus_regfile;
    localparam int N  = 8;
    localparam int WS = 1;
`ifdef FB_BURST_EN
    localparam int BEATS = 4;
`else
    localparam int BEATS = 1;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           ale, cs_n, rw, tbst_n;
    logic [3:0]     be_n;
    logic [31:0]    ad_i;
    logic [31:0]    ad_o;
    logic           oe, ta_n;
    logic [32*N-1:0] qout;
    logic [N-1:0]   stb;

    int             checks = 0;
    int             failures = 0;
    logic [31:0]    model [N];

    int             n_ta, lat;
    int             stb_cnt [N];
    logic [31:0]    rd_seen [4];
    logic           oe_any, oe_at_ta;

    always #5 clk = ~clk;

    perip_flexbus_regfile #(
        .FB_BASE     (32'h6000_0000),
        .N_REGS      (N),
        .WAIT_STATES (WS)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .FB_ALE     (ale),
        .FB_CS_n    (cs_n),
        .FB_RW      (rw),
        .FB_TBST_n  (tbst_n),
        .FB_BE_n    (be_n),
        .FB_AD_I    (ad_i),
        .FB_AD_O    (ad_o),
        .FB_AD_OE   (oe),
        .FB_TA_n    (ta_n),
        .REG_Qout   (qout),
        .REG_WR_STB (stb)
    );

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                                input logic [3:0] ben);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (!ben[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    // Burst beat b of a transaction starting at word idx: wraps within the group of four words.
    function automatic int beat_idx(input int idx, input int b);
        return (idx & ~3) | ((idx + b) & 3);
    endfunction

    // One full bus transaction; observations land in n_ta/lat/rd_seen/stb_cnt/oe_any/oe_at_ta.
    task automatic bus_txn(input logic [31:0] addr, input logic rd, input logic [3:0] ben,
                           input logic burst, input logic [127:0] wd, input int window);
        logic pend;
        n_ta = 0;
        lat = -1;
        oe_any = 1'b0;
        oe_at_ta = 1'b1;
        pend = 1'b0;
        for (int k = 0; k < N; k++) stb_cnt[k] = 0;
        for (int k = 0; k < 4; k++) rd_seen[k] = 32'hxxxx_xxxx;
        @(negedge clk);
        ale = 1'b1; ad_i = addr; tbst_n = ~burst; rw = rd; be_n = ben; cs_n = 1'b1;
        @(negedge clk);
        ale = 1'b0; cs_n = 1'b0; ad_i = wd[31:0];
        for (int c = 1; c <= window; c++) begin
            @(negedge clk);
            if (pend) begin
                ad_i = wd[32*n_ta +: 32];
                pend = 1'b0;
            end
            oe_any = oe_any | oe;
            for (int k = 0; k < N; k++) if (stb[k]) stb_cnt[k]++;
            if (ta_n == 1'b0) begin
                if (n_ta == 0) lat = c;
                if (n_ta < 4) rd_seen[n_ta] = ad_o;
                oe_at_ta = oe_at_ta & oe;
                n_ta++;
                if (n_ta < 4) pend = 1'b1;
            end
        end
        @(negedge clk);
        for (int k = 0; k < N; k++) if (stb[k]) stb_cnt[k]++;
        cs_n = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (qout !== '0) begin failures++; $display("FAIL reset_qout: got %h expected 0", qout); end
        checks++; if (ta_n !== 1'b1) begin failures++; $display("FAIL reset_ta_n: got %b expected 1", ta_n); end
        checks++; if (oe !== 1'b0) begin failures++; $display("FAIL reset_oe: got %b expected 0", oe); end
        checks++; if (ad_o !== 32'h0) begin failures++; $display("FAIL reset_ad_o: got %h expected 0", ad_o); end
        checks++; if (stb !== '0) begin failures++; $display("FAIL reset_stb: got %b expected 0", stb); end
        rst = 1'b0;
        for (int k = 0; k < N; k++) model[k] = 32'h0;
    endtask

    task automatic test_single_write();
        int others;
        bus_txn(32'h6000_0008, 1'b0, 4'b0000, 1'b0, {96'h0, 32'hDEAD_BEEF}, 4);
        model[2] = 32'hDEAD_BEEF;
        others = 0;
        for (int k = 0; k < N; k++) if (k != 2) others += stb_cnt[k];
        checks++; if (n_ta != 1) begin failures++; $display("FAIL wr_ta_count: got %0d expected 1", n_ta); end
        checks++; if (lat != WS + 1) begin failures++; $display("FAIL wr_latency: got %0d expected %0d", lat, WS + 1); end
        checks++; if (qout[64 +: 32] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_reg2: got %h expected deadbeef", qout[64 +: 32]); end
        checks++; if (stb_cnt[2] != 1) begin failures++; $display("FAIL wr_stb2: got %0d pulses expected 1", stb_cnt[2]); end
        checks++; if (others != 0) begin failures++; $display("FAIL wr_stb_other: got %0d pulses expected 0", others); end
    endtask

    task automatic test_byte_lanes();
        bus_txn(32'h6000_0008, 1'b0, 4'b1010, 1'b0, {96'h0, 32'h1122_3344}, 4);
        model[2] = merge_bytes(model[2], 32'h1122_3344, 4'b1010);
        checks++; if (qout[64 +: 32] !== 32'hDE22_BE44) begin failures++; $display("FAIL byte_lane_reg2: got %h expected de22be44", qout[64 +: 32]); end
        checks++; if (qout[64 +: 32] !== model[2]) begin failures++; $display("FAIL byte_lane_model: got %h expected %h", qout[64 +: 32], model[2]); end
    endtask

    task automatic test_read();
        bus_txn(32'h6000_0008, 1'b1, 4'b0000, 1'b0, 128'h0, 4);
        checks++; if (n_ta != 1) begin failures++; $display("FAIL rd_ta_count: got %0d expected 1", n_ta); end
        checks++; if (rd_seen[0] !== model[2]) begin failures++; $display("FAIL rd_data: got %h expected %h", rd_seen[0], model[2]); end
        checks++; if (oe_at_ta !== 1'b1) begin failures++; $display("FAIL rd_oe_at_ta: got %b expected 1", oe_at_ta); end
    endtask

    task automatic test_out_of_range();
        int tot;
        bus_txn(32'h6000_00FC, 1'b1, 4'b0000, 1'b0, 128'h0, 4);
        checks++; if (n_ta != 1) begin failures++; $display("FAIL oor_rd_ta: got %0d expected 1", n_ta); end
        checks++; if (rd_seen[0] !== 32'h0) begin failures++; $display("FAIL oor_rd_data: got %h expected 0", rd_seen[0]); end
        bus_txn(32'h6000_0020, 1'b0, 4'b0000, 1'b0, {96'h0, 32'hCAFE_F00D}, 4);
        tot = 0;
        for (int k = 0; k < N; k++) tot += stb_cnt[k];
        checks++; if (n_ta != 1) begin failures++; $display("FAIL oor_wr_ta: got %0d expected 1", n_ta); end
        checks++; if (tot != 0) begin failures++; $display("FAIL oor_wr_stb: got %0d pulses expected 0", tot); end
        bus_txn(32'h6000_001C, 1'b0, 4'b0000, 1'b0, {96'h0, 32'h7777_0007}, 4);
        model[7] = 32'h7777_0007;
        bus_txn(32'h6000_001C, 1'b1, 4'b0000, 1'b0, 128'h0, 4);
        checks++; if (rd_seen[0] !== model[7]) begin failures++; $display("FAIL last_reg_rd: got %h expected %h", rd_seen[0], model[7]); end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (qout[32*k +: 32] !== model[k]) begin failures++; $display("FAIL oor_regs[%0d]: got %h expected %h", k, qout[32*k +: 32], model[k]); end
        end
    endtask

    task automatic test_base_mismatch();
        bus_txn(32'h7000_0000, 1'b0, 4'b0000, 1'b0, {96'h0, 32'h1234_5678}, 6);
        checks++; if (n_ta != 0) begin failures++; $display("FAIL mis_wr_ta: got %0d expected 0", n_ta); end
        checks++; if (qout[31:0] !== model[0]) begin failures++; $display("FAIL mis_reg0: got %h expected %h", qout[31:0], model[0]); end
        bus_txn(32'h7000_0008, 1'b1, 4'b0000, 1'b0, 128'h0, 6);
        checks++; if (n_ta != 0) begin failures++; $display("FAIL mis_rd_ta: got %0d expected 0", n_ta); end
        checks++; if (oe_any !== 1'b0) begin failures++; $display("FAIL mis_rd_oe: got %b expected 0", oe_any); end
    endtask

    task automatic test_abort();
        int tas, stbs;
        tas = 0; stbs = 0;
        @(negedge clk);
        ale = 1'b1; ad_i = 32'h6000_000C; rw = 1'b0; be_n = 4'b0000; tbst_n = 1'b1; cs_n = 1'b1;
        @(negedge clk);
        ale = 1'b0; cs_n = 1'b0; ad_i = 32'hA5A5_5A5A;
        @(negedge clk);
        cs_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (!ta_n) tas++;
            if (stb != '0) stbs++;
            if (c == 2) cs_n = 1'b0;
        end
        cs_n = 1'b1;
        checks++; if (tas != 0) begin failures++; $display("FAIL abort_ta: got %0d expected 0", tas); end
        checks++; if (stbs != 0) begin failures++; $display("FAIL abort_stb: got %0d expected 0", stbs); end
        checks++; if (qout[96 +: 32] !== model[3]) begin failures++; $display("FAIL abort_reg3: got %h expected %h", qout[96 +: 32], model[3]); end
    endtask

    task automatic test_reset_mid_wait();
        int tas;
        tas = 0;
        @(negedge clk);
        ale = 1'b1; ad_i = 32'h6000_0008; rw = 1'b1; be_n = 4'b0000; tbst_n = 1'b1; cs_n = 1'b1;
        @(negedge clk);
        ale = 1'b0; cs_n = 1'b0;
        @(negedge clk);
        checks++; if (oe !== 1'b1) begin failures++; $display("FAIL midwait_oe_before: got %b expected 1", oe); end
        rst = 1'b1;
        #1;
        checks++; if (oe !== 1'b0) begin failures++; $display("FAIL midwait_oe_after: got %b expected 0", oe); end
        checks++; if (ta_n !== 1'b1) begin failures++; $display("FAIL midwait_ta_after: got %b expected 1", ta_n); end
        for (int k = 0; k < N; k++) model[k] = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (!ta_n) tas++;
        end
        cs_n = 1'b1;
        checks++; if (tas != 0) begin failures++; $display("FAIL midwait_no_ta: got %0d expected 0", tas); end
        checks++; if (qout !== '0) begin failures++; $display("FAIL midwait_regs: got %h expected 0", qout); end
    endtask

    task automatic test_burst();
        bus_txn(32'h6000_0018, 1'b0, 4'b0000, 1'b1, {32'd4, 32'd3, 32'd2, 32'd1}, 14);
        for (int b = 0; b < BEATS; b++) model[beat_idx(6, b)] = 32'(b + 1);
        checks++; if (n_ta != BEATS) begin failures++; $display("FAIL burst_wr_ta: got %0d expected %0d", n_ta, BEATS); end
        for (int k = 4; k < 8; k++) begin
            checks++;
            if (qout[32*k +: 32] !== model[k]) begin failures++; $display("FAIL burst_reg[%0d]: got %h expected %h", k, qout[32*k +: 32], model[k]); end
        end
        bus_txn(32'h6000_0018, 1'b1, 4'b0000, 1'b1, 128'h0, 14);
        checks++; if (n_ta != BEATS) begin failures++; $display("FAIL burst_rd_ta: got %0d expected %0d", n_ta, BEATS); end
        for (int b = 0; b < BEATS; b++) begin
            checks++;
            if (rd_seen[b] !== model[beat_idx(6, b)]) begin failures++; $display("FAIL burst_rd[%0d]: got %h expected %h", b, rd_seen[b], model[beat_idx(6, b)]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        d = $urandom;
        bus_txn(32'h6000_0014, 1'b0, 4'b0000, 1'b0, {96'h0, d}, 2);
        model[5] = d;
        bus_txn(32'h6000_0014, 1'b1, 4'b0000, 1'b0, 128'h0, 4);
        checks++; if (rd_seen[0] !== model[5]) begin failures++; $display("FAIL b2b_rd: got %h expected %h", rd_seen[0], model[5]); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            logic [3:0]  nib;
            logic        hit, inr, rd;
            logic [3:0]  ben;
            logic [31:0] d, exp_rd;
            int          idx, st_tot, bad;
            hit = ($urandom_range(0, 5) != 0);
            nib = hit ? 4'h6 : 4'($urandom_range(7, 15));
            idx = $urandom_range(0, 11);
            rd = 1'($urandom_range(0, 1));
            ben = 4'($urandom);
            d = $urandom;
            inr = hit && (idx < N);
            bus_txn({nib, 20'($urandom), 6'(idx), 2'b00}, rd, ben, 1'b0, {96'h0, d}, 4);
            if (inr && !rd) model[idx] = merge_bytes(model[idx], d, ben);
            exp_rd = inr ? model[idx] : 32'h0;
            st_tot = 0;
            for (int k = 0; k < N; k++) st_tot += stb_cnt[k];
            checks++; if (n_ta != (hit ? 1 : 0)) begin failures++; $display("FAIL rnd_ta it%0d: got %0d expected %0d", it, n_ta, hit ? 1 : 0); end
            if (hit) begin
                checks++; if (lat != WS + 1) begin failures++; $display("FAIL rnd_latency it%0d: got %0d expected %0d", it, lat, WS + 1); end
            end else begin
                checks++; if (oe_any !== 1'b0) begin failures++; $display("FAIL rnd_mis_oe it%0d: got %b expected 0", it, oe_any); end
            end
            if (hit && rd) begin
                checks++; if (rd_seen[0] !== exp_rd) begin failures++; $display("FAIL rnd_rd it%0d: got %h expected %h", it, rd_seen[0], exp_rd); end
                checks++; if (oe_at_ta !== 1'b1) begin failures++; $display("FAIL rnd_oe it%0d: got %b expected 1", it, oe_at_ta); end
            end
            checks++; if (st_tot != ((inr && !rd) ? 1 : 0)) begin failures++; $display("FAIL rnd_stb it%0d: got %0d expected %0d", it, st_tot, (inr && !rd) ? 1 : 0); end
            bad = -1;
            for (int k = 0; k < N; k++) if (bad < 0 && qout[32*k +: 32] !== model[k]) bad = k;
            checks++;
            if (bad >= 0) begin failures++; $display("FAIL rnd_regs it%0d: reg%0d got %h expected %h", it, bad, qout[32*bad +: 32], model[bad]); end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: run exceeded 300000 time units, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ale = 1'b0; cs_n = 1'b1; rw = 1'b1; tbst_n = 1'b1; be_n = 4'hF; ad_i = 32'h0;
        test_reset();
        test_single_write();
        test_byte_lanes();
        test_read();
        test_out_of_range();
        test_base_mismatch();
        test_abort();
        test_reset_mid_wait();
        test_burst();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
